// File: rtl/fir_pkg.sv
// Shared constants and loader state encoding for the FIR coefficient loader.
package fir_pkg;

  localparam int unsigned FIR_N     = 50;
  localparam int unsigned FIR_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CSUM   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_ERR    = 3'd4
  } loader_state_e;

endpackage

// File: rtl/fir_coeff_bank.sv
// Double-buffered coefficient storage: writes land in the shadow bank, reads
// come from the active bank, and a toggle swaps the two roles.
module fir_coeff_bank
  import fir_pkg::*;
#(
  parameter int unsigned N     = FIR_N,
  parameter int unsigned WIDTH = FIR_WIDTH,
  parameter int unsigned AW    = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             toggle,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata_c
);

  logic [WIDTH-1:0] bank0_q [N];
  logic [WIDTH-1:0] bank1_q [N];
  logic             sel_q;

  // sel_q = 0 means bank0 is active and bank1 is the shadow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        bank0_q[i] <= '0;
        bank1_q[i] <= '0;
      end
    end else begin
      if (toggle) begin
        sel_q <= ~sel_q;
      end
      if (we && (32'(waddr) < N)) begin
        if (sel_q) begin
          bank0_q[waddr] <= wdata;
        end else begin
          bank1_q[waddr] <= wdata;
        end
      end
    end
  end

  always_comb begin
    rdata_c = '0;
    if (32'(raddr) < N) begin
      rdata_c = sel_q ? bank1_q[raddr] : bank0_q[raddr];
    end
  end

endmodule

// File: rtl/fir_coeff_loader.sv
// Streams a checksummed coefficient frame into a shadow bank and atomically
// swaps it into the active bank once the checksum verifies.
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int unsigned N     = FIR_N,
  parameter int unsigned WIDTH = FIR_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WIDTH-1:0]     s_data,
  input  logic                 s_last,
  input  logic [$clog2(N)-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 coeff_valid,
  output logic                 swap,
  output logic                 err
);

  localparam int unsigned AW = $clog2(N);
  localparam int unsigned CW = $clog2(N + 1);

  loader_state_e    state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             s_ready_q, s_ready_d;
  logic             swap_q, swap_d;
  logic             err_q, err_d;
  logic             coeff_valid_q, coeff_valid_d;

  logic             accept_c;
  logic             bank_we_c;
  logic [AW-1:0]    bank_waddr_c;
  logic             bank_toggle_c;

  assign accept_c = s_valid && s_ready_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      sum_q         <= '0;
      s_ready_q     <= 1'b1;
      swap_q        <= 1'b0;
      err_q         <= 1'b0;
      coeff_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sum_q         <= sum_d;
      s_ready_q     <= s_ready_d;
      swap_q        <= swap_d;
      err_q         <= err_d;
      coeff_valid_q <= coeff_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (s_last) state_d = ST_ERR;
          else        state_d = (N == 1) ? ST_CSUM : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept_c) begin
          if (s_last)                         state_d = ST_ERR;
          else if (cnt_q == CW'(N - 1))       state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (accept_c) begin
          state_d = (s_last && (s_data == sum_q)) ? ST_COMMIT : ST_ERR;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      ST_ERR:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath updates and the next values of the registered outputs
  always_comb begin
    cnt_d         = cnt_q;
    sum_d         = sum_q;
    bank_we_c     = 1'b0;
    bank_waddr_c  = AW'(cnt_q);
    bank_toggle_c = 1'b0;
    coeff_valid_d = coeff_valid_q;
    s_ready_d     = (state_d == ST_IDLE) || (state_d == ST_LOAD) || (state_d == ST_CSUM);
    swap_d        = (state_d == ST_COMMIT);
    err_d         = (state_d == ST_ERR);
    case (state_q)
      ST_IDLE: begin
        if (accept_c && !s_last) begin
          bank_we_c    = 1'b1;
          bank_waddr_c = '0;
          sum_d        = s_data;
          cnt_d        = CW'(1);
        end
      end
      ST_LOAD: begin
        if (accept_c && !s_last) begin
          bank_we_c = 1'b1;
          sum_d     = sum_q + s_data;
          cnt_d     = cnt_q + CW'(1);
        end
      end
      ST_COMMIT: begin
        bank_toggle_c = 1'b1;
        coeff_valid_d = 1'b1;
        cnt_d         = '0;
        sum_d         = '0;
      end
      ST_ERR: begin
        cnt_d = '0;
        sum_d = '0;
      end
      default: ;
    endcase
  end

  fir_coeff_bank #(
    .N     (N),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .we      (bank_we_c),
    .waddr   (bank_waddr_c),
    .wdata   (s_data),
    .toggle  (bank_toggle_c),
    .raddr   (rd_addr),
    .rdata_c (rd_data)
  );

  assign s_ready     = s_ready_q;
  assign swap        = swap_q;
  assign err         = err_q;
  assign coeff_valid = coeff_valid_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Bench for fir_coeff_loader: frames are judged by a frame-level validity rule
// and the expected active coefficient set is tracked as a plain array.
module tb_fir_coeff_loader;

  localparam int unsigned N  = 50;
  localparam int unsigned W  = 16;
  localparam int unsigned AW = $clog2(N);

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_data;
  logic          s_last;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          coeff_valid;
  logic          swap;
  logic          err;

  int checks   = 0;
  int failures = 0;
  int swap_total = 0;
  int err_total  = 0;

  logic [W-1:0] model_active [N];
  bit           model_cv;
  beat_t        beats [$];

  fir_coeff_loader #(.N(N), .WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .coeff_valid (coeff_valid),
    .swap        (swap),
    .err         (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (swap === 1'b1) swap_total <= swap_total + 1;
    if (err === 1'b1)  err_total  <= err_total + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // A frame is good only if it is exactly N data beats plus a last-flagged checksum
  function automatic bit frame_ok();
    logic [W-1:0] s;
    s = '0;
    if (beats.size() != N + 1) return 1'b0;
    for (int i = 0; i < N; i++) begin
      if (beats[i].last) return 1'b0;
      s = s + beats[i].data;
    end
    return beats[N].last && (beats[N].data == s);
  endfunction

  function automatic logic [W-1:0] exp_rd(int a);
    return (a < int'(N)) ? model_active[a] : '0;
  endfunction

  function automatic void model_commit();
    for (int i = 0; i < N; i++) model_active[i] = beats[i].data;
    model_cv = 1'b1;
  endfunction

  function automatic void build_frame(input logic [W-1:0] base, input logic [W-1:0] step,
                                      input logic [W-1:0] csum);
    logic [W-1:0] v;
    beats.delete();
    v = base;
    for (int i = 0; i < N; i++) begin
      beats.push_back('{data: v, last: 1'b0});
      v = v + step;
    end
    beats.push_back('{data: csum, last: 1'b1});
  endfunction

  task automatic play_frame(input bit gaps, input bit hold, output bit done);
    int guard;
    bit acc;
    done = 1'b1;
    foreach (beats[i]) begin
      if (gaps) begin
        s_valid = 1'b0;
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
      s_valid = 1'b1;
      s_data  = beats[i].data;
      s_last  = beats[i].last;
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 16) begin
        @(negedge clk);
        acc = s_ready;
        @(posedge clk); #1;
        guard++;
      end
      if (!acc) done = 1'b0;
    end
    if (!hold) begin
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; rd_addr = '0;
    for (int i = 0; i < N; i++) model_active[i] = '0;
    model_cv = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", s_ready); end
    checks++; if (coeff_valid !== 1'b0) begin failures++; $display("FAIL reset_cv: got %b want 0", coeff_valid); end
    checks++; if (swap !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_pulses: swap %b err %b want 0 0", swap, err); end
    rd_addr = AW'(49); #1;
    checks++; if (rd_data !== '0) begin failures++; $display("FAIL reset_rd49: got %h want 0", rd_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit done, ok;
    build_frame(16'd1, 16'd1, 16'd1275);
    ok = frame_ok();
    play_frame(1'b0, 1'b0, done);
    checks++; if (!done) begin failures++; $display("FAIL basic_timeout: frame not accepted"); end
    checks++; if (swap !== ok) begin failures++; $display("FAIL basic_swap: got %b want %b", swap, ok); end
    checks++; if (err !== !ok) begin failures++; $display("FAIL basic_err: got %b want %b", err, !ok); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL basic_commit_ready: got %b want 0", s_ready); end
    if (ok) model_commit();
    @(posedge clk); #1;
    checks++; if (swap !== 1'b0) begin failures++; $display("FAIL basic_swap_width: got %b want 0", swap); end
    checks++; if (coeff_valid !== model_cv) begin failures++; $display("FAIL basic_cv: got %b want %b", coeff_valid, model_cv); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_back: got %b want 1", s_ready); end
    rd_addr = AW'(49); #1;
    checks++; if (rd_data !== 16'd50) begin failures++; $display("FAIL basic_rd49: got %0d want 50", rd_data); end
    rd_addr = AW'(0); #1;
    checks++; if (rd_data !== 16'd1) begin failures++; $display("FAIL basic_rd0: got %0d want 1", rd_data); end
    for (int a = 0; a < (1 << AW); a++) begin
      rd_addr = AW'(a); #1;
      checks++;
      if (rd_data !== exp_rd(a)) begin failures++; $display("FAIL basic_sweep[%0d]: got %h want %h", a, rd_data, exp_rd(a)); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bad_csum();
    bit done, ok;
    build_frame(16'd2, 16'd0, 16'd101);
    ok = frame_ok();
    play_frame(1'b0, 1'b0, done);
    checks++; if (!done) begin failures++; $display("FAIL badcs_timeout: frame not accepted"); end
    checks++; if (err !== !ok) begin failures++; $display("FAIL badcs_err: got %b want %b", err, !ok); end
    checks++; if (swap !== ok) begin failures++; $display("FAIL badcs_swap: got %b want %b", swap, ok); end
    @(posedge clk); #1;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL badcs_err_width: got %b want 0", err); end
    checks++; if (coeff_valid !== model_cv) begin failures++; $display("FAIL badcs_cv: got %b want %b", coeff_valid, model_cv); end
    rd_addr = AW'(49); #1;
    checks++; if (rd_data !== exp_rd(49)) begin failures++; $display("FAIL badcs_rd49: got %0d want %0d", rd_data, exp_rd(49)); end
    @(posedge clk); #1;
  endtask

  task automatic test_early_last();
    bit done;
    beats.delete();
    for (int i = 0; i < 9; i++) beats.push_back('{data: 16'd7, last: 1'b0});
    beats.push_back('{data: 16'd7, last: 1'b1});
    play_frame(1'b0, 1'b0, done);
    checks++; if (!done) begin failures++; $display("FAIL early_timeout: beats not accepted"); end
    checks++; if (err !== 1'b1 || swap !== 1'b0) begin failures++; $display("FAIL early_pulse: err %b swap %b want 1 0", err, swap); end
    rd_addr = AW'(3); #1;
    checks++; if (rd_data !== exp_rd(3)) begin failures++; $display("FAIL early_rd3: got %0d want %0d", rd_data, exp_rd(3)); end
    @(posedge clk); #1;
    build_frame(16'd3, 16'd0, 16'd150);
    play_frame(1'b0, 1'b0, done);
    checks++; if (!done) begin failures++; $display("FAIL threes_timeout: frame not accepted"); end
    checks++; if (swap !== frame_ok()) begin failures++; $display("FAIL threes_swap: got %b want %b", swap, frame_ok()); end
    if (frame_ok()) model_commit();
    @(posedge clk); #1;
    rd_addr = AW'(17); #1;
    checks++; if (rd_data !== 16'd3) begin failures++; $display("FAIL threes_rd17: got %0d want 3", rd_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap_hold();
    bit done;
    int e0;
    build_frame(16'h7FFF, 16'd0, 16'hFFCE);
    e0 = err_total;
    play_frame(1'b0, 1'b1, done);
    checks++; if (!done) begin failures++; $display("FAIL wrap_timeout: frame not accepted"); end
    checks++; if (swap !== 1'b1) begin failures++; $display("FAIL wrap_swap: got %b want 1", swap); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL wrap_hold_ready: got %b want 0", s_ready); end
    model_commit();
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (err_total - e0 != 0) begin failures++; $display("FAIL wrap_hold_beat: err pulses %0d want 0", err_total - e0); end
    rd_addr = AW'(25); #1;
    checks++; if (rd_data !== 16'h7FFF) begin failures++; $display("FAIL wrap_rd25: got %h want 7fff", rd_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midframe();
    bit done;
    int s0, e0;
    build_frame(16'd9, 16'd1, 16'd0);
    beats = beats[0:19];
    s0 = swap_total; e0 = err_total;
    play_frame(1'b0, 1'b0, done);
    checks++; if (!done) begin failures++; $display("FAIL midrst_timeout: beats not accepted"); end
    #2 reset = 1'b1;
    for (int i = 0; i < N; i++) model_active[i] = '0;
    model_cv = 1'b0;
    rd_addr = AW'(0); #1;
    checks++; if (coeff_valid !== 1'b0) begin failures++; $display("FAIL midrst_cv: got %b want 0", coeff_valid); end
    checks++; if (rd_data !== '0) begin failures++; $display("FAIL midrst_rd0: got %h want 0", rd_data); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready: got %b want 1", s_ready); end
    checks++; if (swap_total != s0 || err_total != e0) begin failures++; $display("FAIL midrst_pulses: swap %0d err %0d want 0 0", swap_total - s0, err_total - e0); end
    build_frame(16'd1, 16'd1, 16'd1275);
    play_frame(1'b0, 1'b0, done);
    checks++; if (swap !== 1'b1) begin failures++; $display("FAIL midrst_refill_swap: got %b want 1", swap); end
    model_commit();
    @(posedge clk); #1;
    rd_addr = AW'(49); #1;
    checks++; if (rd_data !== 16'd50 || coeff_valid !== 1'b1) begin failures++; $display("FAIL midrst_refill: rd %0d cv %b want 50 1", rd_data, coeff_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_gaps();
    bit done;
    int s0, e0;
    for (int i = 0; i < N; i++) model_active[i] = W'(i + 100);
    build_frame(16'd1, 16'd1, 16'd1275);
    s0 = swap_total; e0 = err_total;
    play_frame(1'b1, 1'b0, done);
    checks++; if (!done) begin failures++; $display("FAIL gaps_timeout: frame not accepted"); end
    model_commit();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (swap_total - s0 != 1) begin failures++; $display("FAIL gaps_swaps: got %0d want 1", swap_total - s0); end
    checks++; if (err_total - e0 != 0) begin failures++; $display("FAIL gaps_errs: got %0d want 0", err_total - e0); end
    for (int a = 0; a < (1 << AW); a++) begin
      rd_addr = AW'(a); #1;
      checks++;
      if (rd_data !== exp_rd(a)) begin failures++; $display("FAIL gaps_sweep[%0d]: got %h want %h", a, rd_data, exp_rd(a)); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit done, ok;
    int mode, cut, a;
    logic [W-1:0] s;
    for (int f = 0; f < 10; f++) begin
      mode = $urandom_range(0, 2);
      beats.delete();
      s = '0;
      for (int i = 0; i < N; i++) begin
        beats.push_back('{data: W'($urandom), last: 1'b0});
        s = s + beats[i].data;
      end
      beats.push_back('{data: s, last: 1'b1});
      if (mode == 1) beats[N].data = s ^ W'($urandom_range(1, 255));
      if (mode == 2) begin
        cut = $urandom_range(0, N - 1);
        beats = beats[0:cut];
        beats[cut].last = 1'b1;
      end
      ok = frame_ok();
      play_frame($urandom_range(0, 1) == 1, 1'b0, done);
      checks++; if (!done) begin failures++; $display("FAIL rand%0d_timeout: frame not accepted", f); end
      checks++; if (swap !== ok || err !== !ok) begin failures++; $display("FAIL rand%0d_pulse: swap %b err %b want %b %b", f, swap, err, ok, !ok); end
      if (ok) model_commit();
      @(posedge clk); #1;
      checks++; if (coeff_valid !== model_cv) begin failures++; $display("FAIL rand%0d_cv: got %b want %b", f, coeff_valid, model_cv); end
      for (int k = 0; k < 4; k++) begin
        a = $urandom_range(0, (1 << AW) - 1);
        rd_addr = AW'(a); #1;
        checks++;
        if (rd_data !== exp_rd(a)) begin failures++; $display("FAIL rand%0d_rd[%0d]: got %h want %h", f, a, rd_data, exp_rd(a)); end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_early_last();
    test_wrap_hold();
    test_reset_midframe();
    test_gaps();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_coeff_loader.md
FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

Interface
REQ-001 SHALL have parameter N, 50, number of filter taps (coefficient words per frame).
REQ-002 SHALL have parameter WIDTH, 16, coefficient and stream word width in bits, two's complement.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port s_valid  input  1  stream word valid.
REQ-006 SHALL have port s_ready  output  1  loader accepts a word this cycle; a transfer occurs when s_valid && s_ready.
REQ-007 SHALL have port s_data  input  WIDTH  stream word: a coefficient, or the checksum on the final beat.
REQ-008 SHALL have port s_last  input  1  marks the checksum beat of a frame.
REQ-009 SHALL have port rd_addr  input  $clog2(N)  coefficient index, 0 = tap applied to newest sample.
REQ-010 SHALL have port rd_data  output  WIDTH  active-bank coefficient at rd_addr, combinational; 0 when rd_addr >= N.
REQ-011 SHALL have port coeff_valid  output  1  active bank holds a committed, checksum-verified set.
REQ-012 SHALL have port swap  output  1  one-cycle pulse when a new set becomes active.
REQ-013 SHALL have port err  output  1  one-cycle pulse when a frame is rejected.

Function
REQ-014 Frame format SHALL be N coefficient words (index 0 first), then one checksum word equal to the sum of the N words mod 2^WIDTH.
REQ-015 Incoming coefficients SHALL be written to the shadow bank only; the active bank SHALL change only on commit.
REQ-016 FSM states SHALL be IDLE, LOAD, CSUM, COMMIT, ERR.
REQ-017 IDLE: s_ready=1; an accepted word with s_last=0 SHALL be written to shadow[0], sum=word, cnt=1, next state LOAD.
REQ-018 LOAD: s_ready=1; each accepted word with s_last=0 SHALL be written to shadow[cnt], added to sum (wrapping at WIDTH bits), and increment cnt; when cnt reaches N, next state CSUM.
REQ-019 An accepted word with s_last=1 in IDLE or LOAD SHALL abort the frame: next state ERR.
REQ-020 CSUM: s_ready=1; an accepted word SHALL go to COMMIT if s_last=1 and s_data==sum, else to ERR.
REQ-021 COMMIT: s_ready=0 for one cycle; bank select SHALL toggle, swap=1, coeff_valid set to 1; next state IDLE.
REQ-022 ERR: s_ready=0 for one cycle; err=1; shadow contents, cnt and sum discarded; active bank and coeff_valid unchanged; next state IDLE.
REQ-023 New coefficients SHALL be visible on rd_data from the cycle after COMMIT; rd_data SHALL never show a partially loaded set.
REQ-024 Cycles with s_valid=0 SHALL leave cnt, sum and state unchanged (gaps allowed anywhere in a frame).
REQ-025 Minimum frame-to-swap latency SHALL be N+2 cycles from the first accepted beat.

Reset
REQ-026 On reset: state IDLE, cnt=0, sum=0, bank select=0, both banks cleared to 0, coeff_valid=0, swap=0, err=0; s_ready=1 from the first cycle after reset deasserts.
REQ-027 Reset mid-frame SHALL discard the partial frame with no err or swap pulse.

Structure
REQ-028 Shared package fir_pkg SHALL hold the default N and WIDTH constants and the loader state enumeration.
REQ-029 Storage SHALL be one sub-module fir_coeff_bank: two N x WIDTH register banks, write port on shadow, combinational read port on active, bank-select toggle input.

Verification
REQ-030 Reset, frame of words 1..50, checksum 1275 with s_last -> swap pulse, coeff_valid=1, rd_addr=49 gives 50, rd_addr=0 gives 1.
REQ-031 After REQ-030, frame of all 2s with checksum 101 -> err pulse, no swap, rd_addr=49 still gives 50.
REQ-032 s_last on the 10th word -> err pulse the next cycle; a following valid frame of all 3s, checksum 150 -> commits, rd_data=3.
REQ-033 50 words of 0x7FFF, checksum 0xFFCE (wrap) -> commits, rd_data=0x7FFF; s_valid held high through COMMIT shows no beat accepted while s_ready=0.
REQ-034 Reset asserted after 20 words of a frame -> coeff_valid=0, rd_data=0, no pulses; a full frame afterwards commits normally.
REQ-035 Frame 1..50 with random s_valid gaps -> identical result to REQ-030, swap exactly once.
